// File: rtl/nios_system_spi_shifter_if.sv
// Avalon-MM slave bus bundle for the SPI shift engine register file.
interface nios_system_spi_shifter_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, read_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/nios_system_spi_shifter.sv
// SPI master shift engine (mode 0, MSB first) with an Avalon-MM register file.
// Clocks data only while the spi_ce PIO level is asserted; dropping it aborts the transfer.
module nios_system_spi_shifter #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIV_DEFAULT = 24
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    nios_system_spi_shifter_if.slave  s_avl,
    input  logic                      i_spi_ce,
    output logic                      o_ss_n,
    output logic                      o_sclk,
    output logic                      o_mosi,
    input  logic                      i_miso
);
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t                r_state, w_next;
    logic [15:0]           r_div, r_hc;
    logic [BW-1:0]         r_bitcnt;
    logic [DATA_WIDTH-1:0] r_shift, r_rxdata;
    logic                  r_rbit, r_sclk, r_mosi_hold;
    logic                  r_rx_valid, r_coll, r_abort;

    logic w_wr, w_rd, w_tx_wr, w_rx_rd, w_stat_wr, w_div_wr;
    logic w_busy, w_start, w_coll_set, w_abort, w_tick, w_last_fall, w_done_ok;

    assign w_wr       = s_avl.chipselect & ~s_avl.write_n;
    assign w_rd       = s_avl.chipselect & ~s_avl.read_n;
    assign w_tx_wr    = w_wr & (s_avl.address == 2'd0);
    assign w_rx_rd    = w_rd & (s_avl.address == 2'd1);
    assign w_stat_wr  = w_wr & (s_avl.address == 2'd2);
    assign w_div_wr   = w_wr & (s_avl.address == 2'd3);

    assign w_busy      = (r_state != ST_IDLE);
    assign w_start     = w_tx_wr & ~w_busy & i_spi_ce;
    assign w_coll_set  = w_tx_wr & ~w_start;
    assign w_abort     = w_busy & ~i_spi_ce;
    assign w_tick      = (r_state == ST_SHIFT) & (r_hc == r_div);
    assign w_last_fall = w_tick & r_sclk & (r_bitcnt == BW'(DATA_WIDTH - 1));
    assign w_done_ok   = (r_state == ST_DONE) & ~w_abort;

    assign o_ss_n = ~i_spi_ce;
    assign o_sclk = r_sclk;
    assign o_mosi = (r_state == ST_SHIFT) ? r_shift[DATA_WIDTH-1] : r_mosi_hold;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = ST_SHIFT;
            ST_SHIFT: if (w_abort) w_next = ST_IDLE;
                      else if (w_last_fall) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div       <= 16'(DIV_DEFAULT);
            r_hc        <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_rxdata    <= '0;
            r_rbit      <= 1'b0;
            r_sclk      <= 1'b0;
            r_mosi_hold <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_coll      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            if (w_div_wr && !w_busy) r_div <= s_avl.writedata[15:0];

            // Sticky flags: a new event in the same cycle as the W1C keeps the bit set.
            r_coll  <= w_coll_set | (r_coll  & ~(w_stat_wr & s_avl.writedata[2]));
            r_abort <= w_abort    | (r_abort & ~(w_stat_wr & s_avl.writedata[3]));

            if (w_start)        r_rx_valid <= 1'b0;
            else if (w_done_ok) r_rx_valid <= 1'b1;
            else if (w_rx_rd)   r_rx_valid <= 1'b0;

            if (w_done_ok) r_rxdata <= r_shift;

            // Remember the bit on the wire so mosi holds it once the engine goes idle.
            if (r_state == ST_SHIFT) r_mosi_hold <= r_shift[DATA_WIDTH-1];

            if (w_abort) begin
                r_sclk   <= 1'b0;
                r_hc     <= '0;
                r_bitcnt <= '0;
            end else if (w_start) begin
                r_shift  <= s_avl.writedata[DATA_WIDTH-1:0];
                r_sclk   <= 1'b0;
                r_hc     <= '0;
                r_bitcnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                if (w_tick) begin
                    r_hc   <= '0;
                    r_sclk <= ~r_sclk;
                    if (!r_sclk) begin
                        r_rbit <= i_miso;
                    end else begin
                        r_shift  <= {r_shift[DATA_WIDTH-2:0], r_rbit};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                end else begin
                    r_hc <= r_hc + 16'd1;
                end
            end
        end
    end

    always_comb begin
        s_avl.readdata = '0;
        case (s_avl.address)
            2'd1:    s_avl.readdata[DATA_WIDTH-1:0] = r_rxdata;
            2'd2:    s_avl.readdata[3:0] = {r_abort, r_coll, r_rx_valid, w_busy};
            2'd3:    s_avl.readdata[15:0] = r_div;
            default: s_avl.readdata = '0;
        endcase
    end
endmodule
